// File: rtl/isqrt32_seq.sv
// ---------------------------------------------------------------------------
// isqrt32_seq
//   Sequential integer square root using the restoring digit-by-digit method.
//   One root bit is resolved per clock, MSB first, so a 2*RW-bit radicand
//   takes RW iteration cycles after the accepting edge.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        request, sampled only in IDLE
//   x      in   2*RW     radicand, captured on the accepting edge
//   busy   out  1        high while iterating (CALC)
//   done   out  1        one-cycle pulse when root/rem are updated
//   root   out  RW       floor(sqrt(x)), held until the next done
//   rem    out  RW+1     x - root*root (always <= 2*root), held likewise
// ---------------------------------------------------------------------------
module isqrt32_seq #(
  parameter int RW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*RW-1:0]   x,
  output logic              busy,
  output logic              done,
  output logic [RW-1:0]     root,
  output logic [RW:0]       rem
);

  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2*RW-1:0] op_q,    op_d;     // radicand, consumed two bits per step
  logic [RW+1:0]   r_q,     r_d;      // partial remainder
  logic [RW-1:0]   q_q,     q_d;      // partial root
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [RW-1:0]   root_q,  root_d;
  logic [RW:0]     rem_q,   rem_d;

  // One iteration of the restoring step. The partial remainder never exceeds
  // 2Q+1, so P fits RW+2 bits and the extra top bit of the RW+3-bit
  // difference is a pure sign bit.
  logic [RW+2:0] p;
  logic [RW+2:0] t;
  logic          t_neg;
  logic [RW+1:0] r_next;
  logic [RW-1:0] q_next;

  assign p      = {r_q[RW:0], op_q[2*RW-1:2*RW-2]};
  assign t      = p - {1'b0, q_q, 2'b01};
  assign t_neg  = t[RW+2];
  assign r_next = t_neg ? p[RW+1:0] : t[RW+1:0];
  assign q_next = {q_q[RW-2:0], ~t_neg};

  // The remainder's top bit is headroom for the invariant above; the
  // step logic itself never needs to read it.
  logic unused_r_msb;
  assign unused_r_msb = r_q[RW+1];

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = x;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = CW'(RW - 1);
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        op_d  = {op_q[2*RW-3:0], 2'b00};
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Publish straight from the last step so the result appears on
          // the same edge that enters DONE.
          root_d  = q_next;
          rem_d   = r_next[RW:0];
          state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;   // start is deliberately ignored here
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);
  assign root = root_q;
  assign rem  = rem_q;

endmodule
